// File: rtl/fetch_stage_pkg.sv
// Shared IF-stage definitions plus the `RESET_PC/`IM_BASE/`NOP_WORD datapath defaults.
// Optional alignment/range checking is compiled in with FETCH_ADDR_CHECK_EN.
`ifndef RESET_PC
`define RESET_PC 32'h0000_3000
`endif
`ifndef IM_BASE
`define IM_BASE 32'h0000_3000
`endif
`ifndef NOP_WORD
`define NOP_WORD 32'h0000_0000
`endif

package fetch_stage_pkg;

   localparam int unsigned XLEN = 32;

   // Encoding is {stall, flush} so the decode is a plain cast.
   typedef enum logic [1:0] {
      CTL_RUN         = 2'b00,
      CTL_FLUSH       = 2'b01,
      CTL_STALL       = 2'b10,
      CTL_STALL_FLUSH = 2'b11
   } if_ctl_e;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic            valid;
`ifdef FETCH_ADDR_CHECK_EN
      logic            fault;
`endif
   } if_id_t;

   function automatic if_ctl_e decode_ctl(input logic stall, input logic flush);
      return if_ctl_e'({stall, flush});
   endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: stall holds, flush injects a bubble (flush wins over stall
// for the instruction side, stall still holds the captured PC). Fault bit under FETCH_ADDR_CHECK_EN.
module if_id_reg
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = `RESET_PC,
   parameter logic [31:0] NOP_WORD = `NOP_WORD
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
`ifdef FETCH_ADDR_CHECK_EN
   input  logic        fault_i,
   output logic        fault_o,
`endif
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic        valid_o
);

   if_id_t q_q;
   if_id_t q_d;

   always_comb begin
      q_d = q_q;
      unique case (decode_ctl(stall_i, flush_i))
         CTL_RUN: begin
            q_d.pc = pc_i;
`ifdef FETCH_ADDR_CHECK_EN
            // A faulty fetch still occupies the slot but never becomes a real instruction.
            if (fault_i) begin
               q_d.instr = NOP_WORD;
               q_d.valid = 1'b0;
               q_d.fault = 1'b1;
            end else begin
               q_d.instr = instr_i;
               q_d.valid = 1'b1;
               q_d.fault = 1'b0;
            end
`else
            q_d.instr = instr_i;
            q_d.valid = 1'b1;
`endif
         end
         CTL_FLUSH: begin
            q_d.pc    = pc_i;
            q_d.instr = NOP_WORD;
            q_d.valid = 1'b0;
`ifdef FETCH_ADDR_CHECK_EN
            q_d.fault = 1'b0;
`endif
         end
         CTL_STALL: begin
         end
         CTL_STALL_FLUSH: begin
            q_d.instr = NOP_WORD;
            q_d.valid = 1'b0;
`ifdef FETCH_ADDR_CHECK_EN
            q_d.fault = 1'b0;
`endif
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         q_q.instr <= NOP_WORD;
         q_q.pc    <= RESET_PC;
         q_q.valid <= 1'b0;
`ifdef FETCH_ADDR_CHECK_EN
         q_q.fault <= 1'b0;
`endif
      end else begin
         q_q <= q_d;
      end
   end

   assign instr_o = q_q.instr;
   assign pc_o    = q_q.pc;
   assign valid_o = q_q.valid;
`ifdef FETCH_ADDR_CHECK_EN
   assign fault_o = q_q.fault;
`endif

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: fetch PC register, IM addressing, delivered-instruction counter, IF/ID register.
// Define FETCH_ADDR_CHECK_EN to add fault_d for misaligned / out-of-IM fetches.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = `RESET_PC,
   parameter logic [31:0] IM_BASE  = `IM_BASE,
   parameter int unsigned IM_AW    = 12,
   parameter logic [31:0] NOP_WORD = `NOP_WORD
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   input  logic [31:0]      next_pc,
   input  logic [31:0]      im_rdata,
   output logic [31:0]      pc_f,
   output logic [IM_AW-1:0] im_addr,
   output logic [31:0]      instr_d,
   output logic [31:0]      pc_d,
   output logic             valid_d,
`ifdef FETCH_ADDR_CHECK_EN
   output logic             fault_d,
`endif
   output logic [31:0]      fetch_cnt
);

   logic [31:0] pc_f_q, pc_f_d;
   logic [31:0] cnt_q, cnt_d;

   always_comb begin
      pc_f_d = pc_f_q;
      cnt_d  = cnt_q;
      if (!stall) begin
         pc_f_d = next_pc;
      end
      // Faulty fetches still count as delivered slots.
      if (!stall && !flush) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_f_q <= RESET_PC;
         cnt_q  <= '0;
      end else begin
         pc_f_q <= pc_f_d;
         cnt_q  <= cnt_d;
      end
   end

   // Word offset from IM_BASE, truncated so out-of-range PCs wrap modulo IM depth.
   assign im_addr = IM_AW'((pc_f_q - IM_BASE) >> 2);

`ifdef FETCH_ADDR_CHECK_EN
   logic fetch_fault;
   assign fetch_fault = (pc_f_q[1:0] != 2'b00) ||
                        (((pc_f_q - IM_BASE) >> (IM_AW + 2)) != 32'd0);
`endif

   if_id_reg #(
      .RESET_PC (RESET_PC),
      .NOP_WORD (NOP_WORD)
   ) u_if_id (
      .clk_i   (clk),
      .reset_i (reset),
      .stall_i (stall),
      .flush_i (flush),
      .instr_i (im_rdata),
      .pc_i    (pc_f_q),
`ifdef FETCH_ADDR_CHECK_EN
      .fault_i (fetch_fault),
      .fault_o (fault_d),
`endif
      .instr_o (instr_d),
      .pc_o    (pc_d),
      .valid_o (valid_d)
   );

   assign pc_f      = pc_f_q;
   assign fetch_cnt = cnt_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline.
  - Holds the architectural fetch PC (PC_F).
  - Drives the instruction-memory address and captures the fetched word into the IF/ID pipeline register.
- Consumes nextPC from the ID-stage next-PC unit.
- Feeds PC_F back to that unit and feeds instr/PC to ID.
- Stall and flush come from the hazard unit.
- Branches use a delay slot, so a taken branch does not flush the slot instruction.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset and first fetch address.
- IM_BASE, 32'h0000_3000, byte address mapped to IM word 0.
- IM_AW, 12, IM word-address width (4096 words).
- NOP_WORD, 32'h0000_0000, word injected as a bubble.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- stall  in  1  hold PC_F and IF/ID this cycle
- flush  in  1  replace IF/ID contents with a bubble
- next_pc  in  32  next fetch address from the next-PC unit
- im_rdata  in  32  combinational IM read data for im_addr
- pc_f  out  32  current fetch PC
- im_addr  out  IM_AW  IM word address
- instr_d  out  32  IF/ID instruction
- pc_d  out  32  IF/ID PC
- valid_d  out  1  IF/ID holds a real instruction
- fetch_cnt  out  32  count of instructions delivered into IF/ID

Behaviour:
- Clock and reset: single clock domain; all state updates on rising clk; reset is synchronous, active-high, and has the highest priority.
- Reset values:
  - pc_f=RESET_PC
  - instr_d=NOP_WORD
  - pc_d=RESET_PC
  - valid_d=0
  - fetch_cnt=0
- Reset asserted mid-stall or mid-flush: the reset values win on that edge. The first real fetch is captured on the first edge after reset deasserts.
- im_addr: combinational, equal to (pc_f - IM_BASE)[IM_AW+1:2]; out-of-range high bits are truncated (wrap modulo IM depth).
- Per edge, when not in reset:
  - stall=0, flush=0: pc_f<=next_pc; instr_d<=im_rdata; pc_d<=pc_f; valid_d<=1; fetch_cnt<=fetch_cnt+1.
  - stall=1, flush=0: all registers hold.
  - stall=0, flush=1: pc_f<=next_pc; instr_d<=NOP_WORD; pc_d<=pc_f; valid_d<=0; fetch_cnt holds.
  - stall=1, flush=1: pc_f holds; instr_d<=NOP_WORD; valid_d<=0; pc_d holds; fetch_cnt holds. Stall wins for the PC, flush wins for IF/ID.
- Latency: an instruction at address A appears on instr_d one edge after pc_f==A with stall=0.
- The next_pc=pc_f+4 default path is computed externally; this block does no PC arithmetic.
- fetch_cnt wraps from 32'hFFFF_FFFF to 0 silently.
- The block does not check alignment unless the optional feature below is compiled in.

Optional Feature:
- Macro: FETCH_ADDR_CHECK_EN.
- Defined:
  - Adds output fault_d (1 bit, reset 0).
  - A fetch is faulty when pc_f[1:0]!=0 or pc_f is outside [IM_BASE, IM_BASE+4*2^IM_AW).
  - On a capturing edge (stall=0, flush=0) with a faulty pc_f: instr_d<=NOP_WORD, valid_d<=0, fault_d<=1, and fetch_cnt still increments.
  - On a flush edge, fault_d<=0.
  - On a stall edge, fault_d holds.
- Undefined: the port is absent; misaligned and out-of-range addresses fetch whatever im_rdata returns.

Decomposition:
- The shared macros header already used by the datapath gets `RESET_PC, `IM_BASE and `NOP_WORD defaults; the parameters default to these.
- One sub-module is natural: if_id_reg, holding instr/pc/valid(/fault) with stall-hold and flush-clear.
- The PC register and fetch_cnt live in fetch_stage.

Test Plan:
- Reset for 2 cycles, then release with next_pc=pc_f+4 and IM word k=0x1000_0000+k:
  - first edge: pc_f 0x3000→0x3004, instr_d=0x1000_0000, pc_d=0x3000, valid_d=1, fetch_cnt=1.
- Stall for 3 cycles at pc_f=0x3008: pc_f, instr_d, pc_d, valid_d and fetch_cnt unchanged throughout; the cycle after release captures word 2.
- Flush alone at pc_f=0x300C with next_pc=0x3040: pc_f=0x3040, instr_d=0, valid_d=0, fetch_cnt unchanged. The next edge delivers the word at 0x3040 with pc_d=0x3040.
- stall=1 and flush=1 together: pc_f holds, instr_d=0, valid_d=0, pc_d holds.
- Assert reset while stall=1 at pc_f=0x3100: next edge gives pc_f=0x3000, valid_d=0, fetch_cnt=0.
- FETCH_ADDR_CHECK_EN defined, next_pc=0x3002, then next_pc=0x7000: both capture edges give fault_d=1, valid_d=0, instr_d=0.
